rrat_multi: RTL
===============

# rrat_multi

Parametrised retirement register alias table (RRAT) for a multi-threaded, multi-wide-commit out-of-order core. It sits behind the per-thread ROBs. Each cycle it retires up to COMMIT_W destination mappings per thread into a per-thread architectural-to-physical map and a per-thread free-list bitmap. Displaced physical registers go into a shared freed-PRN queue, which drains to the front-end free list through a valid/ready handshake. The queue's backpressure stalls commit.

## Interface
Parameters:
- THREADS, 2, number of hardware threads (each with its own map and free list)
- COMMIT_W, 2, commit slots per thread per cycle
- AR_SIZE, 32, architectural registers per thread
- PR_SIZE, 64, physical registers; PRN PR_SIZE-1 is the "no destination" sentinel
- FQ_DEPTH, 8, freed-PRN queue entries; power of 2, at least THREADS*COMMIT_W
- DRAIN_W, 2, freed PRNs presented per cycle
- Derived: AR_BITS=clog2(AR_SIZE), PR_BITS=clog2(PR_SIZE), TID_BITS=max(1,clog2(THREADS))

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- commit_valid  in  THREADS*COMMIT_W  slot [t][s] is retiring
- commit_arn  in  THREADS*COMMIT_W*AR_BITS  architectural destination
- commit_prn  in  THREADS*COMMIT_W*PR_BITS  physical destination (sentinel means no destination)
- commit_ready  out  1  commit accepted this cycle
- rrat_arr  out  THREADS*AR_SIZE*PR_BITS  registered map
- rrat_free_list  out  THREADS*PR_SIZE  registered; bit=1 means the PRN is not mapped in that thread
- free_valid  out  DRAIN_W  lane holds a freed PRN
- free_prn  out  DRAIN_W*PR_BITS  freed PRN
- free_tid  out  DRAIN_W*TID_BITS  owning thread
- free_ready  in  1  consumer takes all valid lanes this cycle

## Operation
- A slot is effective when commit_valid, commit_ready and commit_prn != PR_SIZE-1 all hold. A sentinel PRN is retired with no map change and no free.
- commit_valid while commit_ready=0 is ignored completely. The ROB holds its entries and re-presents them.
- Per thread, slots are applied in order s=0..COMMIT_W-1, oldest first.
- old_prn is the thread's mapping for arn after all older slots of the same cycle have been applied. Example: slots 0 and 1 both write ARN 5; slot 1's old_prn is slot 0's PRN.
- Effective slot updates:
  - Map: map[t][arn] = prn.
  - Free list: free[t][prn] = 0.
  - Displaced PRN: if old_prn != PR_SIZE-1, then free[t][old_prn] = 1 and (old_prn, t) is enqueued.
  - If old_prn equals prn of a younger slot in the same cycle, the clear wins.
- ARN 0 has no special handling. free[t][PR_SIZE-1] is forced to 1.
- Enqueue order within a cycle: thread 0 slots 0..COMMIT_W-1, then thread 1, and so on.
- The queue is a circular buffer with head/tail pointers modulo FQ_DEPTH and a count register.
- Lanes 0..DRAIN_W-1 present the oldest min(count, DRAIN_W) entries, with lane 0 the oldest.
- When free_ready=1, every valid lane dequeues.
- Simultaneous enqueue and dequeue: count_next = count + enq - deq.
- commit_ready = (FQ_DEPTH - count) >= THREADS*COMMIT_W. It uses registered count only and never depends on same-cycle dequeue. The queue cannot overflow.
- Empty queue: all free_valid=0; free_ready is ignored.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - Every map entry = PR_SIZE-1.
  - Every free-list bit = 1.
  - Queue count = 0, pointers = 0.
  - free_valid = 0, free_prn = 0, free_tid = 0, commit_ready = 1.
- Reset mid-operation discards queued PRNs and in-flight commits immediately.
- Latency:
  - Commit at edge N: rrat_arr and rrat_free_list reflect it after edge N.
  - The freed PRN is visible on free_valid in cycle N+1 at the earliest.
- free_* outputs are driven from registered queue state only, never combinationally from commit inputs.
- commit_ready is a function of registered state only.

## Test plan
- Reset check: hold reset low for 2 cycles -> rrat_arr all 63, rrat_free_list all ones, free_valid=0, commit_ready=1.
- Distinct first writes: commit all 4 slots with t0 (ARN 0→PRN 10, 1→11), t1 (2→12, 3→13) -> map updated next cycle, bits 10..13 cleared in the owning thread, no free_valid.
- Overwrite: commit t0 s0 ARN 0→14 and t1 s1 ARN 3→17, others invalid -> free_valid lane0 = (10, t0) and lane1 = (13, t1) next cycle; free bits 10 and 13 set.
- Same-ARN bundle: t0 s0 ARN 7→20, s1 ARN 7→21 (ARN 7 previously 30) -> map[0][7]=21, queue receives 30 then 20, free[0][20]=1 and free[0][21]=0. Also: t0 s0 ARN 6 with PRN 63 -> no change, nothing enqueued.
- Backpressure: free_ready=0, two cycles of 4 displacing commits -> count=8, commit_ready=0, third bundle ignored (map unchanged). Then free_ready=1 -> 2 PRNs per cycle in enqueue order; commit_ready returns once count ≤ 4.
- Async reset: assert reset between clock edges with count=5 -> outputs go to reset values without waiting for a clock edge; after release, free_valid stays 0 until new commits.

Source files
------------

// File: rtl/rrat_multi.sv
// Retirement RAT for a multi-threaded, multi-wide commit core: per-thread arch->phys map and
// free bitmap, plus a shared circular queue of displaced PRNs drained DRAIN_W at a time.
module rrat_multi #(
  parameter  int unsigned THREADS  = 2,
  parameter  int unsigned COMMIT_W = 2,
  parameter  int unsigned AR_SIZE  = 32,
  parameter  int unsigned PR_SIZE  = 64,
  parameter  int unsigned FQ_DEPTH = 8,
  parameter  int unsigned DRAIN_W  = 2,
  localparam int unsigned AR_BITS  = $clog2(AR_SIZE),
  localparam int unsigned PR_BITS  = $clog2(PR_SIZE),
  localparam int unsigned TID_BITS = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [THREADS*COMMIT_W-1:0]         commit_valid,
  input  logic [THREADS*COMMIT_W*AR_BITS-1:0] commit_arn,
  input  logic [THREADS*COMMIT_W*PR_BITS-1:0] commit_prn,
  output logic                                commit_ready,
  output logic [THREADS*AR_SIZE*PR_BITS-1:0]  rrat_arr,
  output logic [THREADS*PR_SIZE-1:0]          rrat_free_list,
  output logic [DRAIN_W-1:0]                  free_valid,
  output logic [DRAIN_W*PR_BITS-1:0]          free_prn,
  output logic [DRAIN_W*TID_BITS-1:0]         free_tid,
  input  logic                                free_ready
);

  localparam int unsigned NSLOT    = THREADS * COMMIT_W;
  localparam int unsigned PTR_BITS = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_BITS = $clog2(FQ_DEPTH + 1);
  localparam logic [PR_BITS-1:0] SENT = PR_BITS'(PR_SIZE - 1);

  logic [PR_BITS-1:0]  map_q [THREADS][AR_SIZE];
  logic [PR_BITS-1:0]  map_d [THREADS][AR_SIZE];
  logic [PR_SIZE-1:0]  free_q [THREADS];
  logic [PR_SIZE-1:0]  free_d [THREADS];

  logic [PR_BITS-1:0]  fq_prn_q [FQ_DEPTH];
  logic [TID_BITS-1:0] fq_tid_q [FQ_DEPTH];
  logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  logic [NSLOT-1:0]    slot_disp;
  logic [PR_BITS-1:0]  slot_old [NSLOT];
  logic [TID_BITS-1:0] slot_tid [NSLOT];
  logic [PTR_BITS-1:0] slot_off [NSLOT];
  logic [CNT_BITS-1:0] enq_cnt, deq_cnt;
  logic [AR_BITS-1:0]  cur_arn;
  logic [PR_BITS-1:0]  cur_prn, cur_old;
  logic                ready;

  // Headroom for a full bundle, judged on registered occupancy only.
  always_comb begin
    ready = (FQ_DEPTH - 32'(count_q)) >= NSLOT;
  end
  assign commit_ready = ready;

  // Slots are applied strictly in order so a younger slot sees older same-cycle writes,
  // and a younger slot's free-bit clear lands after any older slot's set.
  always_comb begin
    map_d   = map_q;
    free_d  = free_q;
    enq_cnt = '0;
    cur_arn = '0;
    cur_prn = '0;
    cur_old = '0;
    slot_disp = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      slot_old[i] = '0;
      slot_tid[i] = '0;
      slot_off[i] = '0;
    end
    for (int unsigned t = 0; t < THREADS; t++) begin
      for (int unsigned s = 0; s < COMMIT_W; s++) begin
        cur_arn = commit_arn[(t*COMMIT_W + s)*AR_BITS +: AR_BITS];
        cur_prn = commit_prn[(t*COMMIT_W + s)*PR_BITS +: PR_BITS];
        slot_off[t*COMMIT_W + s] = PTR_BITS'(enq_cnt);
        if (ready && commit_valid[t*COMMIT_W + s] && (cur_prn != SENT)) begin
          cur_old = map_d[t][cur_arn];
          map_d[t][cur_arn] = cur_prn;
          if (cur_old != SENT) begin
            free_d[t][cur_old] = 1'b1;
            slot_disp[t*COMMIT_W + s] = 1'b1;
            slot_old[t*COMMIT_W + s]  = cur_old;
            slot_tid[t*COMMIT_W + s]  = TID_BITS'(t);
            enq_cnt = enq_cnt + 1'b1;
          end
          free_d[t][cur_prn] = 1'b0;
        end
      end
      free_d[t][PR_SIZE-1] = 1'b1;
    end
  end

  always_comb begin
    deq_cnt = '0;
    if (free_ready) begin
      deq_cnt = (32'(count_q) < DRAIN_W) ? count_q : CNT_BITS'(DRAIN_W);
    end
    head_d  = head_q + PTR_BITS'(deq_cnt);
    tail_d  = tail_q + PTR_BITS'(enq_cnt);
    count_d = count_q + enq_cnt - deq_cnt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned t = 0; t < THREADS; t++) begin
        for (int unsigned a = 0; a < AR_SIZE; a++) begin
          map_q[t][a] <= SENT;
        end
        free_q[t] <= '1;
      end
    end else begin
      map_q  <= map_d;
      free_q <= free_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        fq_prn_q[i] <= '0;
        fq_tid_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        if (slot_disp[i]) begin
          fq_prn_q[tail_q + slot_off[i]] <= slot_old[i];
          fq_tid_q[tail_q + slot_off[i]] <= slot_tid[i];
        end
      end
    end
  end

  // Idle lanes read as zero rather than exposing stale queue contents.
  always_comb begin
    free_valid = '0;
    free_prn   = '0;
    free_tid   = '0;
    for (int unsigned l = 0; l < DRAIN_W; l++) begin
      if (32'(count_q) > l) begin
        free_valid[l]                   = 1'b1;
        free_prn[l*PR_BITS +: PR_BITS]   = fq_prn_q[head_q + PTR_BITS'(l)];
        free_tid[l*TID_BITS +: TID_BITS] = fq_tid_q[head_q + PTR_BITS'(l)];
      end
    end
  end

  always_comb begin
    rrat_arr       = '0;
    rrat_free_list = '0;
    for (int unsigned t = 0; t < THREADS; t++) begin
      for (int unsigned a = 0; a < AR_SIZE; a++) begin
        rrat_arr[(t*AR_SIZE + a)*PR_BITS +: PR_BITS] = map_q[t][a];
      end
      rrat_free_list[t*PR_SIZE +: PR_SIZE] = free_q[t];
    end
  end

endmodule
